// File: rtl/nested_isqrt_pkg.sv
// Shared types and helpers for the nested integer square-root sequencer.
package nested_isqrt_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   // Width of the term index register; never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n_terms);
      return (n_terms <= 1) ? 1 : $clog2(n_terms);
   endfunction

endpackage

// File: rtl/nested_isqrt_add.sv
// Adds a W-bit term to a W/2-bit isqrt result.
// Build option NESTED_ISQRT_SAT_ADD_EN: saturate at 2^W-1 on carry-out;
// default build wraps modulo 2^W.
module nested_isqrt_add #(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0]   a_i,
   input  logic [W/2-1:0] b_i,
   output logic [W-1:0]   sum_c
);

`ifdef NESTED_ISQRT_SAT_ADD_EN
   logic [W:0] full_c;

   // Keep the carry so an overflowing sum clamps to all ones.
   always_comb begin
      full_c = {1'b0, a_i} + (W+1)'(b_i);
      sum_c  = full_c[W] ? '1 : full_c[W-1:0];
   end
`else
   // Plain modulo-2^W sum.
   always_comb begin
      sum_c = a_i + W'(b_i);
   end
`endif

endmodule

// File: rtl/nested_isqrt_fsm.sv
// Nested square root res = isqrt(x[0] + isqrt(x[1] + ... + isqrt(x[N-1])))
// computed by time-multiplexing one external isqrt unit of any latency.
// Build option NESTED_ISQRT_SAT_ADD_EN selects saturating term addition.
module nested_isqrt_fsm
   import nested_isqrt_pkg::*;
#(
   parameter int unsigned N_TERMS = 3,
   parameter int unsigned W       = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 arg_vld,
   output logic                 arg_rdy,
   input  logic [N_TERMS*W-1:0] args,
   output logic                 res_vld,
   output logic [W-1:0]         res,
   output logic                 isqrt_x_vld,
   output logic [W-1:0]         isqrt_x,
   input  logic                 isqrt_y_vld,
   input  logic [W/2-1:0]       isqrt_y
);

   localparam int unsigned IDX_W = idx_w(N_TERMS);

   state_t                 state_q;
   logic [N_TERMS*W-1:0]   arg_q;
   logic [W-1:0]           op_q;
   logic [W-1:0]           op_d;
   logic [IDX_W-1:0]       idx_q;
   logic [W-1:0]           res_q;
   logic                   res_vld_q;
   logic                   x_vld_q;
   logic                   rdy_q;
   logic [W-1:0]           addend_c;

   // Select the next-outer term x[idx-1] from the captured argument set.
   always_comb begin
      addend_c = '0;
      for (int unsigned i = 0; i + 1 < N_TERMS; i++) begin
         if (idx_q == IDX_W'(i + 1)) begin
            addend_c = arg_q[i*W +: W];
         end
      end
   end

   nested_isqrt_add #(
      .W(W)
   ) u_add (
      .a_i   (addend_c),
      .b_i   (isqrt_y),
      .sum_c (op_d)
   );

   // Sequencer: accept a set, then issue/wait once per term, innermost first.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         arg_q     <= '0;
         op_q      <= '0;
         idx_q     <= '0;
         res_q     <= '0;
         res_vld_q <= 1'b0;
         x_vld_q   <= 1'b0;
         rdy_q     <= 1'b1;
      end else begin
         res_vld_q <= 1'b0;
         x_vld_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (arg_vld) begin
                  arg_q   <= args;
                  op_q    <= args[(N_TERMS-1)*W +: W];
                  idx_q   <= IDX_W'(N_TERMS - 1);
                  x_vld_q <= 1'b1;
                  rdy_q   <= 1'b0;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               state_q <= WAIT;
            end
            WAIT: begin
               if (isqrt_y_vld) begin
                  if (idx_q != '0) begin
                     op_q    <= op_d;
                     idx_q   <= idx_q - IDX_W'(1);
                     x_vld_q <= 1'b1;
                     state_q <= ISSUE;
                  end else begin
                     res_q     <= W'(isqrt_y);
                     res_vld_q <= 1'b1;
                     rdy_q     <= 1'b1;
                     state_q   <= IDLE;
                  end
               end
            end
            default: begin
               rdy_q   <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign arg_rdy     = rdy_q;
   assign res_vld     = res_vld_q;
   assign res         = res_q;
   assign isqrt_x_vld = x_vld_q;
   assign isqrt_x     = op_q;

endmodule
